// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - raster-order framebuffer read master with credit-limited pixel FIFO
module framebuffer_scanout #(
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 2048,
  parameter int LINE_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  output logic [$clog2(DEPTH)-1:0] fbAddress,
  output logic                     fbWriteEnable,
  input  logic [WIDTH-1:0]         fbDataIn,
  output logic [WIDTH-1:0]         pixelData,
  output logic                     pixelValid,
  input  logic                     pixelReady,
  output logic                     pixelFirst,
  output logic                     pixelLineEnd,
  output logic                     frameDone,
  output logic                     busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int COLW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int EW   = WIDTH + 3;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     address_q, address_d;
  logic [COLW-1:0]   col_q, col_d;
  logic              inflight_q, inflight_d;
  logic              infl_first_q, infl_first_d;
  logic              infl_line_end_q, infl_line_end_d;
  logic              infl_last_q, infl_last_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic [EW-1:0]     push_entry;
  logic [CNTW-1:0]   credit_used;
  logic              credit_ok;
  logic              last_addr;
  logic              col_end;
  logic              issue;

  assign fifo_empty  = (count_q == '0);
  assign pop         = !fifo_empty && pixelReady;
  assign push        = inflight_q;
  assign head        = fifo_mem_q[rd_ptr_q];
  assign push_entry  = {infl_last_q, infl_line_end_q, infl_first_q, fbDataIn};
  // Credit counts post-pop occupancy plus the read still in the RAM pipeline.
  assign credit_used = count_q - CNTW'(pop) + CNTW'(inflight_q);
  assign credit_ok   = credit_used < CNTW'(FIFO_DEPTH);
  assign last_addr   = (address_q == AW'(DEPTH - 1));
  assign col_end     = (col_q == COLW'(LINE_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   if (issue && last_addr) state_d = enable ? FETCH : DRAIN;
      DRAIN:   if (fifo_empty && !inflight_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The IDLE cycle that sees enable already issues address 0.
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    case (state_q)
      IDLE:  issue = enable && credit_ok;
      FETCH: begin
        issue = credit_ok;
        busy  = 1'b1;
      end
      DRAIN: busy = 1'b1;
      default: begin
        issue = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  always_comb begin
    address_d       = address_q;
    col_d           = col_q;
    inflight_d      = issue;
    infl_first_d    = (address_q == '0);
    infl_line_end_d = col_end;
    infl_last_d     = last_addr;
    if (issue) begin
      address_d = last_addr ? '0 : address_q + 1'b1;
      col_d     = (last_addr || col_end) ? '0 : col_q + 1'b1;
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q       <= '0;
      col_q           <= '0;
      inflight_q      <= 1'b0;
      infl_first_q    <= 1'b0;
      infl_line_end_q <= 1'b0;
      infl_last_q     <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      address_q       <= address_d;
      col_q           <= col_d;
      inflight_q      <= inflight_d;
      infl_first_q    <= infl_first_d;
      infl_line_end_q <= infl_line_end_d;
      infl_last_q     <= infl_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign fbAddress     = address_q;
  assign fbWriteEnable = 1'b0;
  assign pixelValid    = !fifo_empty;
  assign pixelData     = fifo_empty ? '0 : head[WIDTH-1:0];
  assign pixelFirst    = !fifo_empty && head[WIDTH];
  assign pixelLineEnd  = !fifo_empty && head[WIDTH+1];
  assign frameDone     = pop && head[WIDTH+2];

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - scoreboard bench for framebuffer_scanout
module tb_framebuffer_scanout;

  localparam int WIDTH      = 9;
  localparam int DEPTH      = 16;
  localparam int LINE_WIDTH = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [AW-1:0]    fbAddress;
  logic             fbWriteEnable;
  logic [WIDTH-1:0] fbDataIn = '0;
  logic [WIDTH-1:0] pixelData;
  logic             pixelValid;
  logic             pixelReady = 1'b0;
  logic             pixelFirst;
  logic             pixelLineEnd;
  logic             frameDone;
  logic             busy;

  logic [WIDTH-1:0] ram [DEPTH];

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             first;
    logic             line_end;
    logic             done;
    logic             gapless;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;
  int   cyc = 0;
  int   last_acc_cyc = -10;
  int   base;

  framebuffer_scanout #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LINE_WIDTH(LINE_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fbAddress(fbAddress), .fbWriteEnable(fbWriteEnable), .fbDataIn(fbDataIn),
    .pixelData(pixelData), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .pixelFirst(pixelFirst), .pixelLineEnd(pixelLineEnd), .frameDone(frameDone),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fbDataIn <= ram[fbAddress];
    cyc      <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input bit gapless_all, input bit first_gapless);
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.data     = WIDTH'(i);
      e.first    = (i == 0);
      e.line_end = ((i % LINE_WIDTH) == LINE_WIDTH - 1);
      e.done     = (i == DEPTH - 1);
      e.gapless  = gapless_all && ((i != 0) || first_gapless);
      sb.push_back(e);
    end
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_acc_timeout", 32'(acc_cnt >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || pixelValid || sb.size() != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_idle_timeout", 32'(k < budget), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(fbAddress), 0);
    check({tag, "_we"}, 32'(fbWriteEnable), 0);
    check({tag, "_data"}, 32'(pixelData), 0);
    check({tag, "_valid"}, 32'(pixelValid), 0);
    check({tag, "_first"}, 32'(pixelFirst), 0);
    check({tag, "_line_end"}, 32'(pixelLineEnd), 0);
    check({tag, "_done"}, 32'(frameDone), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Every accepted pixel is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pixelValid && pixelReady) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 32'(pixelData), 32'hffff_ffff);
        end else begin
          mon_e = sb.pop_front();
          check("pix_data", 32'(pixelData), 32'(mon_e.data));
          check("pix_first", 32'(pixelFirst), 32'(mon_e.first));
          check("pix_line_end", 32'(pixelLineEnd), 32'(mon_e.line_end));
          check("pix_frame_done", 32'(frameDone), 32'(mon_e.done));
          if (mon_e.gapless) check("pix_gap", 32'(cyc - last_acc_cyc), 1);
        end
        last_acc_cyc = cyc;
        acc_cnt++;
      end else begin
        check("frame_done_idle", 32'(frameDone), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Two back-to-back frames, enable dropped after pixel 5 of the second
    pixelReady = 1'b1;
    push_frame(1'b1, 1'b0);
    push_frame(1'b1, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    check("lat_c0_valid", 32'(pixelValid), 0);
    @(negedge clk);
    check("lat_c1_valid", 32'(pixelValid), 0);
    check("lat_c1_busy", 32'(busy), 1);
    @(negedge clk);
    check("lat_c2_valid", 32'(pixelValid), 1);
    @(posedge clk); #1;
    wait_acc(DEPTH + 6, 100);
    enable = 1'b0;
    wait_idle(100);
    check("drain_busy", 32'(busy), 0);
    check("drain_count", 32'(acc_cnt), 2 * DEPTH);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_restart_valid", 32'(pixelValid), 0);
      check("no_restart_addr", 32'(fbAddress), 0);
    end
    @(posedge clk); #1;

    // Backpressure for 10 cycles after pixel 4 is accepted
    base = acc_cnt;
    push_frame(1'b0, 1'b0);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_acc(base + 5, 50);
    pixelReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(pixelValid), 1);
      check("stall_data", 32'(pixelData), 5);
      if (i >= 5) check("stall_addr", 32'(fbAddress), 32'(5 + FIFO_DEPTH));
    end
    pixelReady = 1'b1;
    wait_idle(100);
    check("stall_count", 32'(acc_cnt), 32'(base + DEPTH));

    // Random ready over three frames
    base = acc_cnt;
    push_frame(1'b0, 1'b0);
    push_frame(1'b0, 1'b0);
    push_frame(1'b0, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      pixelReady = 1'($urandom_range(0, 1));
      if (acc_cnt >= base + 2 * DEPTH + 6) enable = 1'b0;
      if (!enable && !busy && !pixelValid && sb.size() == 0) break;
    end
    pixelReady = 1'b1;
    check("rand_sb_empty", 32'(sb.size()), 0);
    check("rand_count", 32'(acc_cnt), 32'(base + 3 * DEPTH));
    check("rand_busy", 32'(busy), 0);

    // Asynchronous reset mid-frame, then a clean restart
    base = acc_cnt;
    push_frame(1'b0, 1'b0);
    enable = 1'b1;
    wait_acc(base + 7, 50);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    base = acc_cnt;
    push_frame(1'b1, 1'b0);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_idle(100);
    check("restart_count", 32'(acc_cnt), 32'(base + DEPTH));
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
